// File: rtl/motor_period_monitor.sv
// motor_period_monitor
//   Times rising edges of the filtered motor zero-mark and reports the rotation
//   period in clk cycles and the number of completed revolutions. It raises a
//   speed-lock flag after LOCK_CNT consecutive in-tolerance periods and a stall
//   flag when no edge arrives for STALL_CYC cycles.
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   en             : monitor enable, 0 forces IDLE
//   sig_in         : zero-mark level, synchronous to clk
//   target_period  : expected period in cycles (sampled on rise cycles)
//   tol            : allowed |period - target_period| (sampled on rise cycles)
//   period_out     : last measured period, held between updates
//   period_valid   : one-cycle strobe on each period_out update
//   locked, stall  : speed-lock / stall flags
//   rev_cnt        : completed revolutions, wraps at 16 bits
module motor_period_monitor #(
  parameter int CNT_W     = 32,
  parameter int LOCK_CNT  = 4,
  parameter int STALL_CYC = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  input  logic [CNT_W-1:0] target_period,
  input  logic [15:0]      tol,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             locked,
  output logic             stall,
  output logic [15:0]      rev_cnt
);

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_WAIT  = 5'b00010,
    S_MEAS  = 5'b00100,
    S_LOCK  = 5'b01000,
    S_STALL = 5'b10000
  } state_e;

  localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(STALL_CYC - 1);
  localparam logic [3:0]       LOCK_LIM  = 4'(LOCK_CNT);

  state_e           state_q;
  logic             sig_d_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       hit_cnt_q;
  logic [CNT_W-1:0] period_q;
  logic             period_valid_q;
  logic             locked_q;
  logic             stall_q;
  logic [15:0]      rev_cnt_q;

  logic             rise;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W:0]   meas_ext;
  logic [CNT_W:0]   tgt_ext;
  logic [CNT_W:0]   diff;
  logic             in_tol;
  logic             stall_hit;
  logic [3:0]       hit_nxt;

  assign rise = sig_in & ~sig_d_q;

  // Saturating increment; also used as the captured period so a saturated
  // counter reports all-ones instead of wrapping to zero.
  assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  // Tolerance check at CNT_W+1 bits so cnt+1 never overflows.
  assign meas_ext = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign tgt_ext  = {1'b0, target_period};
  assign diff     = (meas_ext >= tgt_ext) ? (meas_ext - tgt_ext) : (tgt_ext - meas_ext);
  assign in_tol   = diff <= {{(CNT_W + 1 - 16){1'b0}}, tol};

  // A rise on the timeout cycle wins over the stall.
  assign stall_hit = ~rise && (cnt_q == STALL_LIM);
  assign hit_nxt   = hit_cnt_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      sig_d_q        <= 1'b0;
      cnt_q          <= '0;
      hit_cnt_q      <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      stall_q        <= 1'b0;
      rev_cnt_q      <= '0;
    end else begin
      sig_d_q        <= sig_in;
      period_valid_q <= 1'b0;
      cnt_q          <= rise ? '0 : cnt_d;
      if (!en) begin
        state_q   <= S_IDLE;
        cnt_q     <= '0;
        hit_cnt_q <= '0;
        locked_q  <= 1'b0;
        stall_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end
          // First rise only opens the timing window.
          S_WAIT: begin
            if (rise) state_q <= S_MEAS;
            else if (stall_hit) begin
              state_q <= S_STALL;
              stall_q <= 1'b1;
            end
          end
          S_MEAS: begin
            if (rise) begin
              period_q       <= cnt_d;
              period_valid_q <= 1'b1;
              rev_cnt_q      <= rev_cnt_q + 16'd1;
              if (in_tol) begin
                hit_cnt_q <= hit_nxt;
                if (hit_nxt == LOCK_LIM) begin
                  state_q  <= S_LOCK;
                  locked_q <= 1'b1;
                end
              end else begin
                hit_cnt_q <= '0;
              end
            end else if (stall_hit) begin
              state_q   <= S_STALL;
              stall_q   <= 1'b1;
              hit_cnt_q <= '0;
            end
          end
          S_LOCK: begin
            if (rise) begin
              period_q       <= cnt_d;
              period_valid_q <= 1'b1;
              rev_cnt_q      <= rev_cnt_q + 16'd1;
              if (!in_tol) begin
                state_q   <= S_MEAS;
                locked_q  <= 1'b0;
                hit_cnt_q <= '0;
              end
            end else if (stall_hit) begin
              state_q   <= S_STALL;
              stall_q   <= 1'b1;
              locked_q  <= 1'b0;
              hit_cnt_q <= '0;
            end
          end
          // Recovery rise restarts timing without reporting a period.
          S_STALL: begin
            if (rise) begin
              state_q <= S_MEAS;
              stall_q <= 1'b0;
            end
          end
          default: begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hit_cnt_q <= '0;
            locked_q  <= 1'b0;
            stall_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign period_out   = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign stall        = stall_q;
  assign rev_cnt      = rev_cnt_q;

endmodule

// File: tb/tb_motor_period_monitor.sv
module tb_motor_period_monitor;

  localparam int CNT_W = 32;
  localparam int STALL = 5000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             sig_in;
  logic [CNT_W-1:0] target_period;
  logic [15:0]      tol;
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic             locked;
  logic             stall;
  logic [15:0]      rev_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  motor_period_monitor #(.CNT_W(CNT_W), .LOCK_CNT(4), .STALL_CYC(STALL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
    .target_period(target_period), .tol(tol),
    .period_out(period_out), .period_valid(period_valid),
    .locked(locked), .stall(stall), .rev_cnt(rev_cnt)
  );

  typedef struct {
    int   period;
    int   target;
    int   tl;
    logic exp_pv;
    int   exp_period;
    logic exp_locked;
    int   exp_rev;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // Rise sampled on the posedge after this negedge; returns at the next negedge.
  task automatic send_rise();
    @(negedge clk) sig_in = 1'b1;
    @(negedge clk) sig_in = 1'b0;
  endtask

  // Rise edge spaced p cycles from the previous one (called right after send_rise).
  task automatic period_gap(input int p);
    repeat (p - 2) @(negedge clk);
    send_rise();
  endtask

  initial begin
    vecs[0]  = '{1000, 1000, 2, 1'b1, 1000, 1'b0, 1};
    vecs[1]  = '{1000, 1000, 2, 1'b1, 1000, 1'b0, 2};
    vecs[2]  = '{1000, 1000, 2, 1'b1, 1000, 1'b0, 3};
    vecs[3]  = '{1000, 1000, 2, 1'b1, 1000, 1'b1, 4};
    vecs[4]  = '{1010, 1000, 2, 1'b1, 1010, 1'b0, 5};
    vecs[5]  = '{1000, 1000, 2, 1'b1, 1000, 1'b0, 6};
    vecs[6]  = '{1000, 1000, 2, 1'b1, 1000, 1'b0, 7};
    vecs[7]  = '{1000, 1000, 2, 1'b1, 1000, 1'b0, 8};
    vecs[8]  = '{1000, 1000, 2, 1'b1, 1000, 1'b1, 9};
    vecs[9]  = '{1002, 1000, 2, 1'b1, 1002, 1'b1, 10};
    vecs[10] = '{998,  1000, 2, 1'b1, 998,  1'b1, 11};
    vecs[11] = '{997,  1000, 2, 1'b1, 997,  1'b0, 12};
    vecs[12] = '{1200, 1200, 0, 1'b1, 1200, 1'b0, 13};

    rst_n = 1'b0; en = 1'b0; sig_in = 1'b0;
    target_period = 1000; tol = 2;
    repeat (3) @(negedge clk);
    chk("rst_period", period_out, 0);
    chk("rst_pv", {31'd0, period_valid}, 0);
    chk("rst_locked", {31'd0, locked}, 0);
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_rev", {16'd0, rev_cnt}, 0);
    rst_n = 1'b1;
    @(negedge clk) en = 1'b1;
    @(negedge clk);

    // first rise only starts timing
    send_rise();
    chk("first_pv", {31'd0, period_valid}, 0);
    chk("first_rev", {16'd0, rev_cnt}, 0);

    for (int i = 0; i < 13; i++) begin
      target_period = vecs[i].target;
      tol = 16'(vecs[i].tl);
      period_gap(vecs[i].period);
      chk($sformatf("v%0d_pv", i), {31'd0, period_valid}, {31'd0, vecs[i].exp_pv});
      chk($sformatf("v%0d_period", i), period_out, vecs[i].exp_period);
      chk($sformatf("v%0d_locked", i), {31'd0, locked}, {31'd0, vecs[i].exp_locked});
      chk($sformatf("v%0d_rev", i), {16'd0, rev_cnt}, vecs[i].exp_rev);
    end

    // rise exactly on the timeout cycle: period reported, no stall
    period_gap(STALL);
    chk("edge_pv", {31'd0, period_valid}, 1);
    chk("edge_period", period_out, STALL);
    chk("edge_stall", {31'd0, stall}, 0);
    chk("edge_rev", {16'd0, rev_cnt}, 14);
    @(negedge clk);
    chk("pv_one_cycle", {31'd0, period_valid}, 0);

    // no more edges: stall exactly STALL cycles after the last rise
    repeat (STALL - 2) @(negedge clk);
    chk("pre_stall", {31'd0, stall}, 0);
    @(negedge clk);
    chk("stall_set", {31'd0, stall}, 1);
    chk("stall_locked", {31'd0, locked}, 0);
    repeat (20) @(negedge clk);
    chk("stall_no_pv", {31'd0, period_valid}, 0);

    // recovery rise restarts timing without a strobe
    target_period = 1000; tol = 2;
    period_gap(100);
    chk("recov_stall", {31'd0, stall}, 0);
    chk("recov_pv", {31'd0, period_valid}, 0);
    chk("recov_rev", {16'd0, rev_cnt}, 14);
    period_gap(1000);
    chk("recov_p_pv", {31'd0, period_valid}, 1);
    chk("recov_period", period_out, 1000);
    chk("recov_p_rev", {16'd0, rev_cnt}, 15);
    repeat (3) period_gap(1000);
    chk("relock", {31'd0, locked}, 1);
    chk("relock_rev", {16'd0, rev_cnt}, 18);

    // en drop while locked
    repeat (50) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("en0_locked", {31'd0, locked}, 0);
    chk("en0_period", period_out, 1000);
    chk("en0_rev", {16'd0, rev_cnt}, 18);
    send_rise();
    chk("en0_rise_pv", {31'd0, period_valid}, 0);
    chk("en0_rise_rev", {16'd0, rev_cnt}, 18);
    repeat (5) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    send_rise();
    chk("reen_first_pv", {31'd0, period_valid}, 0);
    chk("reen_first_rev", {16'd0, rev_cnt}, 18);
    period_gap(700);
    chk("reen_pv", {31'd0, period_valid}, 1);
    chk("reen_period", period_out, 700);
    chk("reen_rev", {16'd0, rev_cnt}, 19);

    // rev_cnt wrap
    force dut.rev_cnt_q = 16'hFFFF;
    #1 release dut.rev_cnt_q;
    period_gap(1000);
    chk("wrap_rev", {16'd0, rev_cnt}, 0);
    chk("wrap_period", period_out, 1000);

    // asynchronous reset mid-period
    repeat (300) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_period", period_out, 0);
    chk("arst_pv", {31'd0, period_valid}, 0);
    chk("arst_locked", {31'd0, locked}, 0);
    chk("arst_stall", {31'd0, stall}, 0);
    chk("arst_rev", {16'd0, rev_cnt}, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
